// File: rtl/stack_ctrl_pkg.sv
// Shared definitions for the RNBIP-2 stack sequencer.
// Holds the op encodings, the FSM state encoding and the default
// STACK_TOP / STACK_LIMIT values used by stack_ctrl and sp_reg.
package stack_defs;

    typedef enum logic [1:0] {
        OP_PUSH = 2'b00,  // write RN
        OP_CALL = 2'b01,  // write NPC
        OP_POP  = 2'b10,  // read into RN
        OP_RET  = 2'b11   // read into PC
    } op_e;

    typedef enum logic [2:0] {
        StIdle   = 3'd0,
        StPushWr = 3'd1,
        StPopInc = 3'd2,
        StPopRd  = 3'd3,
        StErr    = 3'd4
    } state_e;

    localparam logic [7:0] STACK_TOP_DEFAULT   = 8'hFF;
    localparam logic [7:0] STACK_LIMIT_DEFAULT = 8'hE0;

endpackage

// File: rtl/stack_ctrl_sp_reg.sv
// sp_reg: 8-bit stack pointer with increment/decrement enables.
// Ports:
//   clk, rst_n    clock, asynchronous active-low reset (resets to STACK_TOP)
//   inc, dec      pointer step enables (inc wins if both are set)
//   sp            current pointer value
//   is_empty      sp == STACK_TOP
//   is_full       sp == STACK_LIMIT - 1
module sp_reg
    import stack_defs::*;
#(
    parameter logic [7:0] STACK_TOP   = STACK_TOP_DEFAULT,
    parameter logic [7:0] STACK_LIMIT = STACK_LIMIT_DEFAULT
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       inc,
    input  logic       dec,
    output logic [7:0] sp,
    output logic       is_empty,
    output logic       is_full
);

    logic [7:0] sp_d, sp_q;

    always_comb begin
        sp_d = sp_q;
        if (inc) begin
            sp_d = sp_q + 8'd1;
        end else if (dec) begin
            sp_d = sp_q - 8'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sp_q <= STACK_TOP;
        end else begin
            sp_q <= sp_d;
        end
    end

    assign sp       = sp_q;
    assign is_empty = (sp_q == STACK_TOP);
    assign is_full  = (sp_q == STACK_LIMIT - 8'd1);

endmodule

// File: rtl/stack_ctrl.sv
// stack_ctrl: stack sequencer in front of the RNBIP-2 data memory.
// Accepts one-cycle PUSH/CALL/POP/RET requests, drives the memory write enable
// and address/data selects, returns popped bytes and flags overflow/underflow.
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   req, op             request strobe and op code (sampled only when idle)
//   mem_dout            combinational read data from data memory
//   sp_out              stack pointer (memory SP address input)
//   wr, s20, s50        memory write enable, addr select (1=SP), data select (1=RN)
//   busy, done, err     sequence in progress, completion pulse, fault pulse
//   rn_we, pc_we        register-file / PC load strobes
//   pop_data            popped byte, valid while rn_we or pc_we is high
module stack_ctrl
    import stack_defs::*;
#(
    parameter logic [7:0] STACK_TOP   = STACK_TOP_DEFAULT,
    parameter logic [7:0] STACK_LIMIT = STACK_LIMIT_DEFAULT
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       req,
    input  logic [1:0] op,
    input  logic [7:0] mem_dout,
    output logic [7:0] sp_out,
    output logic       wr,
    output logic       s20,
    output logic       s50,
    output logic       busy,
    output logic       done,
    output logic       err,
    output logic       rn_we,
    output logic       pc_we,
    output logic [7:0] pop_data
);

    state_e state_d, state_q;
    op_e    op_d, op_q;

    // Outputs are registered from the next state so they are glitch-free and
    // drop with the asynchronous reset.
    logic wr_d, s20_d, s50_d, busy_d, done_d, err_d, rn_we_d, pc_we_d;
    logic wr_q, s20_q, s50_q, busy_q, done_q, err_q, rn_we_q, pc_we_q;

    logic sp_inc, sp_dec, sp_empty, sp_full;
    logic accept, is_push;

    sp_reg #(
        .STACK_TOP   (STACK_TOP),
        .STACK_LIMIT (STACK_LIMIT)
    ) u_sp_reg (
        .clk      (clk),
        .rst_n    (rst_n),
        .inc      (sp_inc),
        .dec      (sp_dec),
        .sp       (sp_out),
        .is_empty (sp_empty),
        .is_full  (sp_full)
    );

    assign accept  = req && (state_q == StIdle);
    assign is_push = (op_e'(op) == OP_PUSH) || (op_e'(op) == OP_CALL);

    // SP moves on the exit edge of PUSH_WR (post-decrement) and POP_INC (pre-increment).
    assign sp_dec = (state_q == StPushWr);
    assign sp_inc = (state_q == StPopInc);

    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        unique case (state_q)
            StIdle: begin
                if (accept) begin
                    op_d = op_e'(op);
                    if (is_push) begin
                        state_d = sp_full ? StErr : StPushWr;
                    end else begin
                        state_d = sp_empty ? StErr : StPopInc;
                    end
                end
            end
            StPushWr: state_d = StIdle;
            StPopInc: state_d = StPopRd;
            StPopRd:  state_d = StIdle;
            StErr:    state_d = StIdle;
            default:  state_d = StIdle;
        endcase
    end

    always_comb begin
        wr_d    = 1'b0;
        s20_d   = 1'b0;
        s50_d   = 1'b0;
        busy_d  = (state_d != StIdle);
        done_d  = 1'b0;
        err_d   = 1'b0;
        rn_we_d = 1'b0;
        pc_we_d = 1'b0;
        unique case (state_d)
            StPushWr: begin
                wr_d   = 1'b1;
                s20_d  = 1'b1;
                s50_d  = (op_d == OP_PUSH);
                done_d = 1'b1;
            end
            StPopRd: begin
                s20_d   = 1'b1;
                rn_we_d = (op_d == OP_POP);
                pc_we_d = (op_d == OP_RET);
                done_d  = 1'b1;
            end
            StErr: begin
                err_d  = 1'b1;
                done_d = 1'b1;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            op_q    <= OP_PUSH;
            wr_q    <= 1'b0;
            s20_q   <= 1'b0;
            s50_q   <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
            rn_we_q <= 1'b0;
            pc_we_q <= 1'b0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            wr_q    <= wr_d;
            s20_q   <= s20_d;
            s50_q   <= s50_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            err_q   <= err_d;
            rn_we_q <= rn_we_d;
            pc_we_q <= pc_we_d;
        end
    end

    assign wr       = wr_q;
    assign s20      = s20_q;
    assign s50      = s50_q;
    assign busy     = busy_q;
    assign done     = done_q;
    assign err      = err_q;
    assign rn_we    = rn_we_q;
    assign pc_we    = pc_we_q;
    // Memory reads at SP during POP_RD; zero otherwise so the bus is quiet.
    assign pop_data = (rn_we_q || pc_we_q) ? mem_dout : 8'h00;

endmodule

// File: doc/stack_ctrl.md
# stack_ctrl

Stack sequencer for the RNBIP-2 data path, sitting directly upstream of the data memory. Owns the 8-bit stack pointer and, on a one-cycle request from the decoder, sequences PUSH, CALL, POP and RET. It drives the memory's write enable, address-select (SP vs R0) and data-select (RN vs NPC) controls, then captures popped data for the register file or PC. It also detects stack overflow and underflow.

## Interface
- STACK_TOP, default 8'hFF: SP reset value; stack empty when SP == STACK_TOP.
- STACK_LIMIT, default 8'hE0: lowest writable stack address; full when SP == STACK_LIMIT-1 (capacity 32).
- clk  in  1  system clock; all state changes on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- req  in  1  op request, sampled only when busy=0.
- op  in  2  00 PUSH (RN), 01 CALL (NPC), 10 POP (to RN), 11 RET (to PC).
- mem_dout  in  8  combinational read data from data memory.
- sp_out  out  8  stack pointer register; drives memory SP input.
- wr  out  1  data memory write enable.
- s20  out  1  address select: 1 = SP, 0 = R0.
- s50  out  1  write-data select: 1 = RN, 0 = NPC.
- busy  out  1  sequence in progress.
- done  out  1  one-cycle completion pulse.
- err  out  1  one-cycle overflow/underflow pulse; coincides with done.
- rn_we  out  1  register-file write strobe (POP).
- pc_we  out  1  PC load strobe (RET).
- pop_data  out  8  popped byte; valid while rn_we or pc_we = 1.

## Operation
- Empty-descending stack:
  - push writes at SP, then SP <= SP-1.
  - pop does SP <= SP+1, then reads at the new SP.
- States: IDLE, PUSH_WR, POP_INC, POP_RD, ERR.
- IDLE:
  - Outputs: busy=0, wr=0, s20=0 (R0 addressing left to normal loads/stores).
  - On req with op PUSH/CALL: go to PUSH_WR, or to ERR if SP == STACK_LIMIT-1.
  - On req with op POP/RET: go to POP_INC, or to ERR if SP == STACK_TOP.
- PUSH_WR:
  - Outputs: wr=1, s20=1, s50 = (op==PUSH), done=1.
  - Exit edge: SP <= SP-1, go to IDLE.
- POP_INC:
  - Outputs: s20=0, wr=0.
  - Exit edge: SP <= SP+1, go to POP_RD.
- POP_RD:
  - Outputs: s20=1, pop_data = mem_dout, rn_we = (op==POP), pc_we = (op==RET), done=1.
  - Exit edge: go to IDLE.
- ERR:
  - Outputs: err=1, done=1.
  - No memory write, SP unchanged. Exit edge: go to IDLE.
- op is latched at acceptance; later changes on the op input are ignored.
- req while busy=1 is dropped, not queued.
- SP arithmetic is 8-bit modulo, but the full/empty checks prevent wrap in legal use.
- All control outputs decode from state and latched op only (Moore). wr never depends on req combinationally.

## Timing
- Reset values: SP=STACK_TOP, state IDLE, all strobes 0, s20=0, s50=0, pop_data=0.
- Reset is asynchronous. Asserting rst_n mid-sequence forces wr=0 immediately, with no memory write on the next edge.
- Accept at edge T (req=1 and busy=0 sampled).
- PUSH/CALL: write cycle T..T+1, done in the same cycle. The memory write and SP decrement occur at edge T+1.
- POP/RET: POP_INC in T..T+1, POP_RD in T+1..T+2 with done. The data strobe is sampled by the consumer at edge T+2.
- ERR: err and done high T..T+1.
- Back-to-back: the next req is accepted at the first edge after done; maximum throughput is one push per 2 cycles and one pop per 3 cycles.
- sp_out updates only on push/pop edges and is stable during PUSH_WR and POP_RD.

## Structure
- Shared package stack_defs holds:
  - op encodings OP_PUSH/OP_CALL/OP_POP/OP_RET;
  - state encodings;
  - defaults for STACK_TOP/STACK_LIMIT.
- One natural sub-module, sp_reg: 8-bit up/down register with async active-low reset to STACK_TOP, inc/dec enables, plus is_empty/is_full flags computed from the parameters.
- The FSM and output decode live in stack_ctrl.

## Test plan
- Reset, then PUSH with RN=8'h5A → T+1: wr=1, s20=1, s50=1, sp_out=8'hFF, done=1; after the edge, mem[FF]=5A and sp_out=8'hFE.
- CALL with NPC=8'h42 after the above → wr at address 8'hFE with s50=0; mem[FE]=42, sp_out=8'hFD.
- RET then POP → RET: pc_we=1, pop_data=8'h42 two cycles after accept. POP: rn_we=1, pop_data=8'h5A. Final sp_out=8'hFF; wr stays 0 throughout.
- POP from empty (SP=8'hFF) → err=1 and done=1 for one cycle, wr=0, rn_we=0, sp_out stays 8'hFF.
- 32 PUSHes fill the stack (sp_out=8'hDF); the 33rd PUSH → err=1, no wr, mem[DF] unchanged.
- req asserted during busy is ignored. rst_n dropped in PUSH_WR → wr=0 immediately, memory unchanged, sp_out=8'hFF, state IDLE.
